// File: rtl/esc_spi_pkg.sv
// Shared constants and helpers for the ESC SPI access master.
// Holds the opcodes, the FSM state encodings and the maximum frame length.
// It also provides helpers that build the MOSI frame and give the header length.
package esc_spi_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_WRITE     = 8'h02;

  // Longest frame: opcode + 2 addr + dummy + 4 data bytes
  localparam int unsigned MAX_FRAME_BITS = 64;
  localparam int unsigned BIT_CNT_W      = 7;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_CS_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  // Left-aligned MOSI frame. Bits past the real frame length are never shifted out.
  function automatic logic [MAX_FRAME_BITS-1:0] build_frame(
    input logic        write,
    input logic        fast,
    input logic [15:0] addr,
    input logic [31:0] wdata
  );
    if (write)
      build_frame = {OP_WRITE, addr, wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24], 8'h00};
    else if (fast)
      build_frame = {OP_FAST_READ, addr, 40'h0};
    else
      build_frame = {OP_READ, addr, 40'h0};
  endfunction

  // Bits before the first data bit. Fast reads add the dummy byte.
  function automatic logic [BIT_CNT_W-1:0] header_bits(input logic write, input logic fast);
    header_bits = (!write && fast) ? BIT_CNT_W'(32) : BIT_CNT_W'(24);
  endfunction

endpackage

// File: rtl/esc_spi_sclk_gen.sv
// SCLK generator: the level toggles every CLK_DIV clk cycles while en is high.
// The rise_c and fall_c strobes mark the clk edge at which SCLK goes high or low.
// Ports: clk, reset (async, active high), en, sclk (registered level), rise_c, fall_c.
module esc_spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             term_c;

  assign term_c = en && (cnt == CNT_W'(CLK_DIV - 1));
  assign rise_c = term_c && !sclk;
  assign fall_c = term_c && sclk;

  // Half-period counter. Disabling the generator parks SCLK low with a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (term_c) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/esc_spi_access_master.sv
// SPI command engine for the ESC SPI port (LAN9252 style, SPI mode 0).
// It takes register read and write requests on a valid/ready interface and serialises them as:
//   opcode, addr[15:8], addr[7:0], [dummy], data bytes, each byte MSB first.
// Read data is returned with resp_valid.
// Build option: define ESC_SPI_FAST_READ_EN to use opcode 0x0B plus one dummy byte for reads.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   req_valid/ready     request handshake; req_write, req_addr, req_len, req_wdata are the fields
//   resp_valid          one-cycle pulse at transaction end, with resp_rdata (0 for writes)
//   busy                high from accept until the inter-frame gap ends
//   esc_eepdone         asynchronous EEPROM-loaded flag; blocks new accepts while low
//   spi_sclk/cs_n/mosi  SPI outputs; spi_miso is the SPI input
module esc_spi_access_master
  import esc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [1:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy,
  input  logic        esc_eepdone,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

`ifdef ESC_SPI_FAST_READ_EN
  localparam logic FAST_READ = 1'b1;
`else
  localparam logic FAST_READ = 1'b0;
`endif

  localparam int unsigned PH_W = 16;

  logic [2:0]                state, state_nxt;
  logic [PH_W-1:0]           ph_cnt;
  logic                      eep_s1, eep_s2;
  logic [MAX_FRAME_BITS-1:0] tx_sr;
  logic [BIT_CNT_W-1:0]      bit_cnt, frame_bits, hdr_bits;
  logic                      is_write;
  logic [31:0]               rx_data;

  logic                      accept_c, sclk_en_c, rise_c, fall_c;
  logic                      last_bit_c, hold_end_c;
  logic [MAX_FRAME_BITS-1:0] frame_c;
  logic [BIT_CNT_W-1:0]      hdr_c, len_bits_c;
  logic [4:0]                data_off_c, rx_idx_c;

  assign accept_c   = req_valid && req_ready;
  assign sclk_en_c  = (state == ST_SHIFT);
  assign frame_c    = build_frame(req_write, FAST_READ, req_addr, req_wdata);
  assign hdr_c      = header_bits(req_write, FAST_READ);
  assign len_bits_c = {1'b0, ({1'b0, req_len} + 3'd1), 3'b000};
  assign last_bit_c = fall_c && (bit_cnt == frame_bits - BIT_CNT_W'(1));
  assign hold_end_c = (state == ST_CS_HOLD) && (ph_cnt == PH_W'(CLK_DIV - 1));
  // Data bytes arrive byte0 first and MSB first. The bit offset maps to {byte, 7-bit}.
  assign data_off_c = 5'(bit_cnt - hdr_bits);
  assign rx_idx_c   = {data_off_c[4:3], ~data_off_c[2:0]};

  esc_spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk    (clk),
    .reset  (reset),
    .en     (sclk_en_c),
    .sclk   (spi_sclk),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (accept_c)                         state_nxt = ST_CS_SETUP;
      ST_CS_SETUP: if (ph_cnt == PH_W'(CLK_DIV - 1))     state_nxt = ST_SHIFT;
      ST_SHIFT:    if (last_bit_c)                       state_nxt = ST_CS_HOLD;
      ST_CS_HOLD:  if (hold_end_c)                       state_nxt = ST_GAP;
      ST_GAP:      if (ph_cnt == PH_W'(CS_GAP - 1))      state_nxt = ST_IDLE;
      default:                                           state_nxt = ST_IDLE;
    endcase
  end

  // Phase counter for the setup, hold and gap intervals. It restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          ph_cnt <= '0;
    else if (state_nxt != state)                        ph_cnt <= '0;
    else if (state != ST_IDLE && state != ST_SHIFT)     ph_cnt <= ph_cnt + 1'b1;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eep_s1     <= 1'b0;
      eep_s2     <= 1'b0;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      spi_cs_n   <= 1'b1;
      spi_mosi   <= 1'b0;
      tx_sr      <= '0;
      bit_cnt    <= '0;
      frame_bits <= '0;
      hdr_bits   <= '0;
      is_write   <= 1'b0;
      rx_data    <= '0;
    end else begin
      resp_valid <= 1'b0;
      eep_s1     <= esc_eepdone;
      eep_s2     <= eep_s1;
      // Registered form of (state==IDLE && eep_s2), one cycle ahead of use
      req_ready  <= (state_nxt == ST_IDLE) && eep_s1;
      busy       <= (state_nxt != ST_IDLE);

      if (accept_c) begin
        tx_sr      <= frame_c;
        spi_mosi   <= frame_c[MAX_FRAME_BITS-1];
        spi_cs_n   <= 1'b0;
        bit_cnt    <= '0;
        hdr_bits   <= hdr_c;
        frame_bits <= hdr_c + len_bits_c;
        is_write   <= req_write;
        rx_data    <= '0;
      end

      // MISO is only captured during read data bits
      if (rise_c && !is_write && (bit_cnt >= hdr_bits))
        rx_data[rx_idx_c] <= spi_miso;

      if (fall_c) begin
        bit_cnt  <= bit_cnt + 1'b1;
        tx_sr    <= tx_sr << 1;
        spi_mosi <= last_bit_c ? 1'b0 : tx_sr[MAX_FRAME_BITS-2];
      end

      if (hold_end_c) begin
        spi_cs_n   <= 1'b1;
        resp_valid <= 1'b1;
        resp_rdata <= is_write ? 32'h0 : rx_data;
      end
    end
  end

endmodule

// File: tb/tb_esc_spi_access_master.sv
// Testbench for esc_spi_access_master.
// Stimulus pushes the expected response of each request into a scoreboard queue.
// A monitor watches the SPI pins and checks each resp_valid against the queue head.
module tb_esc_spi_access_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [1:0]  req_len;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;
  logic        esc_eepdone;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    int          rises;
    int          cs_low;
    logic [63:0] mosi;
  } exp_t;

  exp_t sb_q[$];

  esc_spi_access_master #(.CLK_DIV(4), .CS_GAP(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .busy        (busy),
    .esc_eepdone (esc_eepdone),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ESC MISO model: it presents bit miso_idx of a left-aligned stream. The index advances after each SCLK rise.
  logic [63:0] miso_stream = '0;
  logic [6:0]  miso_idx = '0;
  always @(posedge spi_sclk or posedge spi_cs_n) begin
    if (spi_cs_n) miso_idx <= '0;
    else          miso_idx <= miso_idx + 7'd1;
  end
  assign spi_miso = miso_idx[6] ? 1'b0 : miso_stream[~miso_idx[5:0]];

`ifdef ESC_SPI_FAST_READ_EN
  localparam int HDR = 32;
`else
  localparam int HDR = 24;
`endif

  // Header bits are all ones so that any capture during opcode or address shows up in rdata
  function automatic logic [63:0] mk_stream(input logic [31:0] payload_msb);
    logic [63:0] ones = 64'hFFFF_FFFF_FFFF_FFFF;
    logic [63:0] pay  = {payload_msb, 32'h0};
    mk_stream = ~(ones >> HDR) | (pay >> HDR);
  endfunction

  // Monitor: samples on the falling clk edge
  int          mon_rises = 0;
  int          lo_cnt = 0;
  int          hi_cnt = 0;
  logic [63:0] cap = '0;
  logic        in_frame = 1'b0;
  logic        had_frame = 1'b0;
  logic        prev_sclk = 1'b0;
  int          resp_seen = 0;

  always @(negedge clk) begin
    if (reset) begin
      in_frame  = 1'b0;
      had_frame = 1'b0;
      hi_cnt    = 0;
      prev_sclk = 1'b0;
    end else begin
      if (resp_valid) begin
        exp_t e;
        resp_seen++;
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_resp: got resp_valid with rdata 0x%0h, expected no response", resp_rdata);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("txn%0d_rdata", e.id), 64'(resp_rdata), 64'(e.rdata));
          chk($sformatf("txn%0d_rises", e.id), 64'(mon_rises), 64'(e.rises));
          chk($sformatf("txn%0d_cs_low", e.id), 64'(lo_cnt), 64'(e.cs_low));
          chk($sformatf("txn%0d_mosi", e.id), (mon_rises == 0) ? 64'h0 : (cap << (64 - mon_rises)), e.mosi);
        end
        in_frame  = 1'b0;
        had_frame = 1'b1;
        hi_cnt    = 0;
      end
      if (!spi_cs_n && !in_frame) begin
        in_frame = 1'b1;
        if (had_frame) chk("cs_gap_ge_8", 64'(hi_cnt >= 8), 64'd1);
        mon_rises = 0;
        lo_cnt    = 0;
        cap       = '0;
      end
      if (!spi_cs_n) lo_cnt++;
      else           hi_cnt++;
      if (spi_sclk && !prev_sclk) begin
        mon_rises++;
        cap = {cap[62:0], spi_mosi};
      end
      prev_sclk = spi_sclk;
    end
  end

  // Called at a falling edge. Holds valid until accept and can push the expected response at accept.
  task automatic issue(input logic wr, input logic [15:0] a, input logic [1:0] len,
                       input logic [31:0] wd, input logic hold, input logic push,
                       input exp_t e, output int waited);
    req_write = wr;
    req_addr  = a;
    req_len   = len;
    req_wdata = wd;
    req_valid = 1'b1;
    waited    = 0;
    while (!req_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
    end else begin
      @(posedge clk);
      if (push) sb_q.push_back(e);
      #1;
    end
    if (!hold) req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int   w;
    int   viol;
    exp_t e;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    req_wdata   = '0;
    esc_eepdone = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sclk", 64'(spi_sclk), 64'd0);
    chk("rst_cs_n", 64'(spi_cs_n), 64'd1);
    chk("rst_mosi", 64'(spi_mosi), 64'd0);
    reset = 1'b0;

    // EEPROM not done: the request is held off
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h1234; req_len = 2'd1; req_wdata = 32'h0000_A55A;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (req_ready || spi_sclk || !spi_cs_n) viol++;
    end
    chk("eep_block_violations", 64'(viol), 64'd0);
    esc_eepdone = 1'b1;
    e = '{id: 4, rdata: 32'h0, rises: 40, cs_low: 328, mosi: 64'h0212_345A_A500_0000};
    issue(1'b1, 16'h1234, 2'd1, 32'h0000_A55A, 1'b0, 1'b1, e, w);
    chk("eep_accept_le_3", 64'((w + 1) <= 3), 64'd1);
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_idle();
    chk("ready_after_idle", 64'(req_ready), 64'd1);

    // Write, 4 bytes
    e = '{id: 1, rdata: 32'h0, rises: 56, cs_low: 456, mosi: 64'h0230_00EF_BEAD_DE00};
    issue(1'b1, 16'h3000, 2'd3, 32'hDEAD_BEEF, 1'b0, 1'b1, e, w);
    wait_idle();

    // Read, 4 bytes
    miso_stream = mk_stream(32'h2143_6587);
`ifdef ESC_SPI_FAST_READ_EN
    e = '{id: 2, rdata: 32'h8765_4321, rises: 64, cs_low: 520, mosi: 64'h0B00_6400_0000_0000};
`else
    e = '{id: 2, rdata: 32'h8765_4321, rises: 56, cs_low: 456, mosi: 64'h0300_6400_0000_0000};
`endif
    issue(1'b0, 16'h0064, 2'd3, 32'hFFFF_FFFF, 1'b0, 1'b1, e, w);
    wait_idle();

    // Read, 1 byte: the trailing stream is ones, so upper rdata bytes must stay 0
    miso_stream = mk_stream(32'h11FF_FFFF);
`ifdef ESC_SPI_FAST_READ_EN
    e = '{id: 3, rdata: 32'h0000_0011, rises: 40, cs_low: 328, mosi: 64'h0B00_5000_0000_0000};
`else
    e = '{id: 3, rdata: 32'h0000_0011, rises: 32, cs_low: 264, mosi: 64'h0300_5000_0000_0000};
`endif
    issue(1'b0, 16'h0050, 2'd0, 32'h0, 1'b0, 1'b1, e, w);
    wait_idle();

    // Back-to-back requests with valid held; the second frame is reset mid-address
    e = '{id: 5, rdata: 32'h0, rises: 32, cs_low: 264, mosi: 64'h0201_20C3_0000_0000};
    issue(1'b1, 16'h0120, 2'd0, 32'h0000_00C3, 1'b1, 1'b1, e, w);
    issue(1'b1, 16'h0ABC, 2'd2, 32'h0011_2233, 1'b1, 1'b0, e, w);
    w = 0;
    while ((spi_cs_n || mon_rises < 12) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("b2b_second_frame_reached", 64'(w < 3000), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_cs_n", 64'(spi_cs_n), 64'd1);
    chk("abort_sclk", 64'(spi_sclk), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    viol = resp_seen;
    repeat (600) @(negedge clk);
    chk("abort_no_resp", 64'(resp_seen - viol), 64'd0);

    // Recovery after the abort
    e = '{id: 7, rdata: 32'h0, rises: 32, cs_low: 264, mosi: 64'h0200_107E_0000_0000};
    issue(1'b1, 16'h0010, 2'd0, 32'h0000_007E, 1'b0, 1'b1, e, w);
    wait_idle();

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
